// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and parameter legality checks for the flagged sync FIFO
package fifo_pkg;
  localparam int DEF_DSIZE = 8;
  localparam int DEF_ASIZE = 4;
  function automatic bit af_ok(input int t, input int depth);
    return t >= 1 && t <= depth;
  endfunction
  function automatic bit ae_ok(input int t, input int depth);
    return t >= 0 && t < depth;
  endfunction
endpackage

// File: rtl/sync_fifo_flags_if.sv
// sync_fifo_flags_if: data, handshake and status bundle of the flagged sync FIFO
interface sync_fifo_flags_if import fifo_pkg::*; #(
  parameter int DSIZE = DEF_DSIZE,
  parameter int ASIZE = DEF_ASIZE
);
  logic [DSIZE-1:0] wdata, rdata;
  logic winc, rinc, flush, clr_err;
  logic rvalid, wfull, rempty, walmost_full, ralmost_empty, wovf, rudf;
  logic [ASIZE:0] count;
  modport master(
    output wdata, winc, rinc, flush, clr_err,
    input rdata, rvalid, wfull, rempty, walmost_full, ralmost_empty, count, wovf, rudf
  );
  modport slave(
    input wdata, winc, rinc, flush, clr_err,
    output rdata, rvalid, wfull, rempty, walmost_full, ralmost_empty, count, wovf, rudf
  );
endinterface

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: one clocked write port, asynchronous read port, no reset on contents
module sync_fifo_ram #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);
  logic [DSIZE-1:0] mem [2**ASIZE];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with count-decoded flags, sticky errors, flush and optional FWFT
module sync_fifo_flags import fifo_pkg::*; #(
  parameter int DSIZE     = DEF_DSIZE,
  parameter int ASIZE     = DEF_ASIZE,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = (2**ASIZE) - 2,
  parameter int AE_THRESH = 2
) (
  input logic clk,
  input logic rst_n,
  sync_fifo_flags_if.slave f
);
  localparam int DEPTH = 2**ASIZE;
  localparam logic [ASIZE:0] FULL = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AF = (ASIZE+1)'(AF_THRESH);
  localparam logic [ASIZE:0] AE = (ASIZE+1)'(AE_THRESH);
  if (!af_ok(AF_THRESH, DEPTH) || !ae_ok(AE_THRESH, DEPTH)) begin : g_bad_thresh
    $error("sync_fifo_flags: AF_THRESH or AE_THRESH out of range");
  end
  logic [ASIZE-1:0] waddr, raddr;
  logic [ASIZE:0] count;
  logic [DSIZE-1:0] rd, rdata_q;
  logic rvalid_q, wovf, rudf, wfull, rempty, we, re;
  assign wfull  = count == FULL;
  assign rempty = count == '0;
  assign we = f.winc && !wfull && !f.flush;
  assign re = f.rinc && !rempty && !f.flush;
  sync_fifo_ram #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_ram (
    .clk(clk), .we(we), .waddr(waddr), .wdata(f.wdata), .raddr(raddr), .rdata(rd)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      waddr    <= '0;
      raddr    <= '0;
      count    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wovf     <= 1'b0;
      rudf     <= 1'b0;
    end else begin
      waddr    <= f.flush ? '0 : waddr + ASIZE'(we);
      raddr    <= f.flush ? '0 : raddr + ASIZE'(re);
      count    <= f.flush ? '0 : count + (ASIZE+1)'(we) - (ASIZE+1)'(re);
      rdata_q  <= re ? rd : rdata_q;
      rvalid_q <= re;
      wovf     <= (f.winc && wfull && !f.flush) || (wovf && !f.clr_err);
      rudf     <= (f.rinc && rempty && !f.flush) || (rudf && !f.clr_err);
    end
  assign f.rdata         = FWFT != 0 ? rd : rdata_q;
  assign f.rvalid        = FWFT != 0 ? !rempty : rvalid_q;
  assign f.wfull         = wfull;
  assign f.rempty        = rempty;
  assign f.walmost_full  = count >= AF;
  assign f.ralmost_empty = count <= AE;
  assign f.count         = count;
  assign f.wovf          = wovf;
  assign f.rudf          = rudf;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed checks of a registered-read and a FWFT instance
module tb_sync_fifo_flags;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  sync_fifo_flags_if #(.DSIZE(8), .ASIZE(4)) fa ();
  sync_fifo_flags_if #(.DSIZE(8), .ASIZE(4)) fb ();
  sync_fifo_flags #(.DSIZE(8), .ASIZE(4), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .f(fa)
  );
  sync_fifo_flags #(.DSIZE(8), .ASIZE(4), .FWFT(1), .AF_THRESH(14), .AE_THRESH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .f(fb)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] d);
    fa.winc = 1'b1;
    fa.wdata = d;
    cyc();
    fa.winc = 1'b0;
  endtask
  task automatic rd();
    fa.rinc = 1'b1;
    cyc();
    fa.rinc = 1'b0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_count"}, 32'(fa.count), 0);
    chk({tag, "_rempty"}, 32'(fa.rempty), 1);
    chk({tag, "_rae"}, 32'(fa.ralmost_empty), 1);
    chk({tag, "_wfull"}, 32'(fa.wfull), 0);
    chk({tag, "_waf"}, 32'(fa.walmost_full), 0);
    chk({tag, "_rdata"}, 32'(fa.rdata), 0);
    chk({tag, "_rvalid"}, 32'(fa.rvalid), 0);
    chk({tag, "_wovf"}, 32'(fa.wovf), 0);
    chk({tag, "_rudf"}, 32'(fa.rudf), 0);
    chk({tag, "_b_rempty"}, 32'(fb.rempty), 1);
  endtask
  initial begin
    {fa.winc, fa.rinc, fa.flush, fa.clr_err} = '0;
    {fb.winc, fb.rinc, fb.flush, fb.clr_err} = '0;
    fa.wdata = '0;
    fb.wdata = '0;
    #3;
    chk_reset("rst");
    rst_n = 1'b1;
    cyc();
    chk("rst_release_count", 32'(fa.count), 0);
    for (int i = 0; i < 16; i++) begin
      wr(8'(i));
      chk("fill_count", 32'(fa.count), 32'(i + 1));
      chk("fill_waf", 32'(fa.walmost_full), 32'(i + 1 >= 14));
      chk("fill_rae", 32'(fa.ralmost_empty), 32'(i + 1 <= 2));
      chk("fill_wfull", 32'(fa.wfull), 32'(i == 15));
    end
    chk("full_wovf_pre", 32'(fa.wovf), 0);
    wr(8'hFF);
    chk("ovf_count", 32'(fa.count), 16);
    chk("ovf_wovf", 32'(fa.wovf), 1);
    for (int i = 0; i < 16; i++) begin
      rd();
      chk("drain_data", 32'(fa.rdata), 32'(i));
      chk("drain_rvalid", 32'(fa.rvalid), 1);
      chk("drain_count", 32'(fa.count), 32'(15 - i));
      chk("drain_rae", 32'(fa.ralmost_empty), 32'(15 - i <= 2));
    end
    chk("drain_rempty", 32'(fa.rempty), 1);
    cyc();
    chk("rvalid_pulse", 32'(fa.rvalid), 0);
    chk("rdata_hold", 32'(fa.rdata), 32'h0F);
    fa.clr_err = 1'b1;
    cyc();
    fa.clr_err = 1'b0;
    chk("clr_wovf", 32'(fa.wovf), 0);
    for (int i = 0; i < 16; i++) wr(8'h10 + 8'(i));
    fa.winc = 1'b1; fa.rinc = 1'b1; fa.wdata = 8'h77;
    cyc();
    fa.winc = 1'b0; fa.rinc = 1'b0;
    chk("full_both_count", 32'(fa.count), 15);
    chk("full_both_data", 32'(fa.rdata), 32'h10);
    chk("full_both_wovf", 32'(fa.wovf), 1);
    for (int i = 1; i < 16; i++) begin
      rd();
      chk("full_both_drain", 32'(fa.rdata), 32'h10 + 32'(i));
    end
    fa.winc = 1'b1; fa.rinc = 1'b1; fa.wdata = 8'h3C;
    cyc();
    fa.winc = 1'b0; fa.rinc = 1'b0;
    chk("empty_both_count", 32'(fa.count), 1);
    chk("empty_both_rudf", 32'(fa.rudf), 1);
    chk("empty_both_rvalid", 32'(fa.rvalid), 0);
    fa.clr_err = 1'b1;
    cyc();
    fa.clr_err = 1'b0;
    chk("clr_both_wovf", 32'(fa.wovf), 0);
    chk("clr_both_rudf", 32'(fa.rudf), 0);
    rd();
    chk("empty_both_data", 32'(fa.rdata), 32'h3C);
    fa.rinc = 1'b1; fa.clr_err = 1'b1;
    cyc();
    fa.rinc = 1'b0;
    chk("set_wins_rudf", 32'(fa.rudf), 1);
    cyc();
    fa.clr_err = 1'b0;
    chk("clr_rudf", 32'(fa.rudf), 0);
    wr(8'hA5);
    chk("a5_rvalid_pre", 32'(fa.rvalid), 0);
    rd();
    chk("a5_data", 32'(fa.rdata), 32'hA5);
    chk("a5_rvalid", 32'(fa.rvalid), 1);
    cyc();
    chk("a5_rvalid_drop", 32'(fa.rvalid), 0);
    chk("a5_hold", 32'(fa.rdata), 32'hA5);
    for (int i = 0; i < 16; i++) wr(8'h80 + 8'(i));
    wr(8'hFF);
    chk("flush_pre_wovf", 32'(fa.wovf), 1);
    fa.flush = 1'b1; fa.winc = 1'b1; fa.rinc = 1'b1; fa.wdata = 8'hEE;
    cyc();
    fa.flush = 1'b0; fa.winc = 1'b0; fa.rinc = 1'b0;
    chk("flush_count", 32'(fa.count), 0);
    chk("flush_rempty", 32'(fa.rempty), 1);
    chk("flush_wfull", 32'(fa.wfull), 0);
    chk("flush_wovf", 32'(fa.wovf), 1);
    chk("flush_rudf", 32'(fa.rudf), 0);
    chk("flush_rvalid", 32'(fa.rvalid), 0);
    fa.clr_err = 1'b1;
    cyc();
    fa.clr_err = 1'b0;
    wr(8'h5A);
    rd();
    chk("post_flush_data", 32'(fa.rdata), 32'h5A);
    chk("post_flush_rempty", 32'(fa.rempty), 1);
    wr(8'h40);
    for (int i = 1; i < 40; i++) begin
      fa.winc = 1'b1; fa.rinc = 1'b1; fa.wdata = 8'h40 + 8'(i);
      cyc();
      chk("wrap_data", 32'(fa.rdata), 32'h40 + 32'(i - 1));
      chk("wrap_count", 32'(fa.count), 1);
    end
    fa.winc = 1'b0; fa.rinc = 1'b0;
    rd();
    chk("wrap_last", 32'(fa.rdata), 32'h67);
    fb.winc = 1'b1; fb.wdata = 8'hA5;
    cyc();
    fb.wdata = 8'h3B;
    cyc();
    fb.winc = 1'b0;
    chk("fwft_data", 32'(fb.rdata), 32'hA5);
    chk("fwft_rvalid", 32'(fb.rvalid), 1);
    chk("fwft_count", 32'(fb.count), 2);
    fb.rinc = 1'b1;
    cyc();
    chk("fwft_next", 32'(fb.rdata), 32'h3B);
    cyc();
    fb.rinc = 1'b0;
    chk("fwft_rempty", 32'(fb.rempty), 1);
    chk("fwft_rvalid_lo", 32'(fb.rvalid), 0);
    fb.winc = 1'b1; fb.wdata = 8'hC6;
    cyc();
    fb.winc = 1'b0;
    chk("fwft_one_cycle", 32'(fb.rdata), 32'hC6);
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    rd();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    chk("mid_rst_b_count", 32'(fb.count), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_rempty", 32'(fa.rempty), 1);
    wr(8'h99);
    rd();
    chk("post_rst_data", 32'(fa.rdata), 32'h99);
    chk("post_rst_rempty2", 32'(fa.rempty), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
